line_ring_scanout: RTL and testbench
====================================

Name: line_ring_scanout

Overview:
- Single-clock, N-line ring of line buffers between the PSRAM fetch path and LCD scanout.
- Replaces the fixed two-buffer ping-pong with:
  - configurable line depth, pixel width and resolution
  - a valid/ready fill handshake
  - integer vertical line repeat (upscaling)
  - frame resynchronisation
  - underrun detection with black fill
- Upstream delivers pixels already in the clk_pixel domain through its own CDC FIFO. Downstream is the LCD timing generator, which supplies de_in, vsync_in and x_pos.

Parameters:
- H_RES, 800, active pixels per line; 2..2048.
- PIX_W, 24, pixel width in bits.
- N_LINES, 4, ring depth; power of two, >= 2.
- REP_W, 2, width of the vertical repeat field; repeat factor is cfg_v_repeat + 1.

Ports:
- clk_pixel  in  1  pixel clock; all logic on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cfg_v_repeat  in  REP_W  extra displays per line; sampled only at vsync_in rising edge.
- wr_valid  in  1  fill pixel valid.
- wr_ready  out  1  fill pixel accepted when wr_valid && wr_ready.
- wr_data  in  PIX_W  fill pixel.
- de_in  in  1  display enable from timing generator.
- vsync_in  in  1  vertical sync from timing generator, active-high.
- x_pos  in  COL_W  active column; valid while de_in = 1.
- rd_pixel  out  PIX_W  pixel to panel, registered.
- rd_de  out  1  de_in delayed 1 cycle, aligned with rd_pixel.
- line_req  out  1  1-cycle pulse: one ring slot freed.
- frame_start  out  1  1-cycle pulse: ring flushed at vsync.
- fill_level  out  LINE_W+1  committed lines in the ring, 0..N_LINES.
- underrun  out  1  sticky; cleared only by reset.

Behaviour:
Reset values:
- All outputs 0 except rd_pixel = 0 (black).
- wr_line, wr_col, rd_line, rep_cnt and count are 0.

Fill side:
- wr_ready = (count < N_LINES) && !flush.
- Each accept writes RAM[{wr_line, wr_col}] and increments wr_col.
- On the accept with wr_col = H_RES-1:
  - wr_col <= 0 and wr_line <= wr_line+1, wrapping modulo N_LINES.
  - The line is committed: count increments.
- There is no partial-line commit.

Scanout side:
- RAM read address is {rd_line, x_pos}; read latency is 1 cycle.
- rd_pixel <= (de_in && line_ok) ? RAM data : 0.
- line_ok is latched on the de_in rising edge as (count != 0).
- If count = 0 at the de_in rising edge:
  - line_ok <= 0 and underrun <= 1.
  - That line shows black.
  - At its end nothing is released and rep_cnt is unchanged.

End of line (de_in falling edge, line_ok = 1):
- If rep_cnt < cfg_v_repeat_latched: rep_cnt++ and the same line is shown again.
- Otherwise:
  - rep_cnt <= 0, rd_line++ (wrapping).
  - count decrements.
  - line_req pulses one cycle later.

count arithmetic:
- Commit and release in the same cycle: count unchanged.
- Width is LINE_W+1; it never exceeds N_LINES (guaranteed by wr_ready) and never goes below 0 (guaranteed by line_ok).

Frame sync (vsync_in rising edge):
- flush for one cycle; wr_ready = 0 that cycle.
- On the next cycle:
  - wr_line, wr_col, rd_line, rep_cnt and count are set to 0.
  - cfg_v_repeat is latched.
  - frame_start pulses.
  - Any partial line being written is discarded.
- Flush takes priority over a simultaneous commit or release.
- Producer restarts the frame on frame_start and may prefill up to N_LINES lines before the first de_in.

Other rules:
- fill_level = count.
- Reset mid-line: immediate return to reset state; rd_pixel goes to 0.

Optional Feature:
- UNDERRUN_CNT_EN
  - Defined:
    - Adds output underrun_cnt, 16 bits.
    - Increments by 1 on every underrun line, saturating at 16'hFFFF.
    - Not cleared by vsync; cleared only by rst_n.
  - Undefined:
    - Port and counter are absent.
    - Only the sticky underrun flag exists.

Decomposition:
- Package line_ring_pkg:
  - clog2 function.
  - COL_W = clog2(H_RES); LINE_W = clog2(N_LINES).
  - PIX_BLACK constant.
- Sub-module line_ring_ram:
  - Simple dual-port, single clock, depth N_LINES*2^COL_W, width PIX_W.
  - Write port and registered read port; no read-during-write bypass is required, since the fill side never writes the slot being scanned.

Test Plan:
1. Prefill: H_RES=8, N_LINES=4, wr_valid held high, no de_in -> exactly 32 pixels accepted, then wr_ready = 0, fill_level = 4.
2. Scanout: 4 lines filled with pixel value {line, col}; de_in asserted for 8 cycles with x_pos 0..7 -> rd_pixel shows those values with 1-cycle lag aligned to rd_de; line_req pulses once per line; fill_level steps 4→3.
3. Repeat: cfg_v_repeat = 2 latched at vsync -> each ring line is shown on 3 consecutive de_in periods; line_req pulses on every 3rd line end only.
4. Underrun: empty ring, one de_in line -> rd_pixel = 0 throughout, underrun = 1, no line_req, rd_line unchanged; with UNDERRUN_CNT_EN, underrun_cnt = 1.
5. Simultaneous events: a commit on the same cycle as the de_in falling-edge release -> fill_level unchanged. A vsync during a partial line (wr_col = 5) -> frame_start pulses, fill_level = 0, the next accepted pixel lands at {0, 0}.
6. Async reset asserted mid-line -> all outputs 0 immediately without a clock edge; after release, prefill and scanout behave as in scenario 1.

Source files
------------

// File: rtl/line_ring_pkg.sv
// Shared helpers and constants for the line ring scanout block.
// The optional per-line underrun counter is enabled with UNDERRUN_CNT_EN.
package line_ring_pkg;

  // Ceiling log2 used to size column and line address fields.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

  // Black pixel bit, replicated to the pixel width where used.
  localparam logic PIX_BLACK = 1'b0;

endpackage

// File: rtl/line_ring_ram.sv
// Simple dual-port line storage: one write port, one registered read port.
// The read register can be forced to black so the scanout output comes
// straight from it.
module line_ring_ram
  import line_ring_pkg::*;
#(
  parameter int AW    = 5,
  parameter int PIX_W = 24
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [PIX_W-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  input  logic             rzero_i,
  output logic [PIX_W-1:0] rdata_o
);

  logic [PIX_W-1:0] mem_q [1 << AW];
  logic [PIX_W-1:0] rdata_q;

  // Storage array write port.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read port; forced black when the line must not be shown.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= {PIX_W{PIX_BLACK}};
    end else if (rzero_i) begin
      rdata_q <= {PIX_W{PIX_BLACK}};
    end else begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/line_ring_scanout.sv
// N-line ring of line buffers between the fetch path and LCD scanout, with
// vertical line repeat, vsync resynchronisation and underrun black fill.
// Defining UNDERRUN_CNT_EN adds a saturating 16-bit underrun line counter.
module line_ring_scanout
  import line_ring_pkg::*;
#(
  parameter  int H_RES   = 800,
  parameter  int PIX_W   = 24,
  parameter  int N_LINES = 4,
  parameter  int REP_W   = 2,
  localparam int COL_W   = clog2(H_RES),
  localparam int LINE_W  = clog2(N_LINES)
) (
  input  logic              clk_pixel,
  input  logic              rst_n,
  input  logic [REP_W-1:0]  cfg_v_repeat,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [PIX_W-1:0]  wr_data,
  input  logic              de_in,
  input  logic              vsync_in,
  input  logic [COL_W-1:0]  x_pos,
  output logic [PIX_W-1:0]  rd_pixel,
  output logic              rd_de,
  output logic              line_req,
  output logic              frame_start,
  output logic [LINE_W:0]   fill_level,
  output logic              underrun
`ifdef UNDERRUN_CNT_EN
  ,output logic [15:0]      underrun_cnt
`endif
);

  localparam logic [LINE_W:0]  COUNT_MAX = (LINE_W+1)'(N_LINES);
  localparam logic [LINE_W:0]  COUNT_ONE = (LINE_W+1)'(1);
  localparam logic [COL_W-1:0] LAST_COL  = COL_W'(H_RES - 1);

  logic              de_q, vs_q, line_ok_q, run_q;
  logic              rd_de_q, line_req_q, frame_start_q, underrun_q;
  logic [LINE_W-1:0] wr_line_q, wr_line_d, rd_line_q, rd_line_d;
  logic [COL_W-1:0]  wr_col_q, wr_col_d;
  logic [REP_W-1:0]  rep_cnt_q, rep_cnt_d, rep_lat_q, rep_lat_d;
  logic [LINE_W:0]   count_q, count_d;
  logic              line_req_d;

  logic flush_s, de_rise_s, de_fall_s, wr_ready_s, accept_s, commit_s;
  logic line_ok_s, line_end_s, release_s, underrun_line_s, rzero_s;

  // Edge detection and fill/scanout event decode.
  always_comb begin
    flush_s         = vsync_in & ~vs_q;
    de_rise_s       = de_in & ~de_q;
    de_fall_s       = ~de_in & de_q;
    wr_ready_s      = run_q && (count_q < COUNT_MAX) && !flush_s;
    accept_s        = wr_valid & wr_ready_s;
    commit_s        = accept_s && (wr_col_q == LAST_COL);
    underrun_line_s = de_rise_s && (count_q == {(LINE_W+1){1'b0}});
    line_ok_s       = de_rise_s ? !underrun_line_s : line_ok_q;
    line_end_s      = de_fall_s & line_ok_q;
    release_s       = line_end_s && (rep_cnt_q >= rep_lat_q) && !flush_s;
    rzero_s         = !(de_in && line_ok_s);
  end

  // Next-state for pointers, repeat counter and line count; flush wins.
  always_comb begin
    wr_col_d   = wr_col_q;
    wr_line_d  = wr_line_q;
    rd_line_d  = rd_line_q;
    rep_cnt_d  = rep_cnt_q;
    rep_lat_d  = rep_lat_q;
    count_d    = count_q;
    line_req_d = 1'b0;
    if (flush_s) begin
      wr_col_d  = {COL_W{1'b0}};
      wr_line_d = {LINE_W{1'b0}};
      rd_line_d = {LINE_W{1'b0}};
      rep_cnt_d = {REP_W{1'b0}};
      rep_lat_d = cfg_v_repeat;
      count_d   = {(LINE_W+1){1'b0}};
    end else begin
      if (accept_s) begin
        if (commit_s) begin
          wr_col_d  = {COL_W{1'b0}};
          wr_line_d = wr_line_q + LINE_W'(1);
        end else begin
          wr_col_d  = wr_col_q + COL_W'(1);
        end
      end else begin
        wr_col_d = wr_col_q;
      end
      if (line_end_s) begin
        if (release_s) begin
          rep_cnt_d  = {REP_W{1'b0}};
          rd_line_d  = rd_line_q + LINE_W'(1);
          line_req_d = 1'b1;
        end else begin
          rep_cnt_d  = rep_cnt_q + REP_W'(1);
        end
      end else begin
        rep_cnt_d = rep_cnt_q;
      end
      case ({commit_s, release_s})
        2'b10:   count_d = count_q + COUNT_ONE;
        2'b01:   count_d = count_q - COUNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // State and registered status outputs.
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      de_q          <= 1'b0;
      vs_q          <= 1'b0;
      run_q         <= 1'b0;
      line_ok_q     <= 1'b0;
      rd_de_q       <= 1'b0;
      line_req_q    <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      wr_col_q      <= {COL_W{1'b0}};
      wr_line_q     <= {LINE_W{1'b0}};
      rd_line_q     <= {LINE_W{1'b0}};
      rep_cnt_q     <= {REP_W{1'b0}};
      rep_lat_q     <= {REP_W{1'b0}};
      count_q       <= {(LINE_W+1){1'b0}};
    end else begin
      de_q          <= de_in;
      vs_q          <= vsync_in;
      run_q         <= 1'b1;
      line_ok_q     <= line_ok_s;
      rd_de_q       <= de_in;
      line_req_q    <= line_req_d;
      frame_start_q <= flush_s;
      underrun_q    <= underrun_q | underrun_line_s;
      wr_col_q      <= wr_col_d;
      wr_line_q     <= wr_line_d;
      rd_line_q     <= rd_line_d;
      rep_cnt_q     <= rep_cnt_d;
      rep_lat_q     <= rep_lat_d;
      count_q       <= count_d;
    end
  end

`ifdef UNDERRUN_CNT_EN
  logic [15:0] urun_cnt_q;

  // Saturating count of lines shown black because the ring was empty.
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      urun_cnt_q <= 16'h0000;
    end else if (underrun_line_s && (urun_cnt_q != 16'hFFFF)) begin
      urun_cnt_q <= urun_cnt_q + 16'h0001;
    end else begin
      urun_cnt_q <= urun_cnt_q;
    end
  end

  assign underrun_cnt = urun_cnt_q;
`endif

  line_ring_ram #(
    .AW    (LINE_W + COL_W),
    .PIX_W (PIX_W)
  ) u_ram (
    .clk_i   (clk_pixel),
    .rst_ni  (rst_n),
    .we_i    (accept_s),
    .waddr_i ({wr_line_q, wr_col_q}),
    .wdata_i (wr_data),
    .raddr_i ({rd_line_q, x_pos}),
    .rzero_i (rzero_s),
    .rdata_o (rd_pixel)
  );

  assign wr_ready    = wr_ready_s;
  assign rd_de       = rd_de_q;
  assign line_req    = line_req_q;
  assign frame_start = frame_start_q;
  assign fill_level  = count_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_line_ring_scanout.sv
// Scoreboard bench for line_ring_scanout with H_RES=8, N_LINES=4.
module tb_line_ring_scanout;

  localparam int H  = 8;
  localparam int N  = 4;
  localparam int PW = 24;
  localparam int RW = 2;

  logic          clk_pixel = 1'b0;
  logic          rst_n;
  logic [RW-1:0] cfg_v_repeat;
  logic          wr_valid;
  logic          wr_ready;
  logic [PW-1:0] wr_data;
  logic          de_in;
  logic          vsync_in;
  logic [2:0]    x_pos;
  logic [PW-1:0] rd_pixel;
  logic          rd_de;
  logic          line_req;
  logic          frame_start;
  logic [2:0]    fill_level;
  logic          underrun;
`ifdef UNDERRUN_CNT_EN
  logic [15:0]   underrun_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int lr_cnt = 0;
  int fs_cnt = 0;
  logic [PW-1:0] exp_q[$];

  line_ring_scanout #(.H_RES(H), .PIX_W(PW), .N_LINES(N), .REP_W(RW)) dut (
    .clk_pixel    (clk_pixel),
    .rst_n        (rst_n),
    .cfg_v_repeat (cfg_v_repeat),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_data      (wr_data),
    .de_in        (de_in),
    .vsync_in     (vsync_in),
    .x_pos        (x_pos),
    .rd_pixel     (rd_pixel),
    .rd_de        (rd_de),
    .line_req     (line_req),
    .frame_start  (frame_start),
    .fill_level   (fill_level),
    .underrun     (underrun)
`ifdef UNDERRUN_CNT_EN
    ,.underrun_cnt(underrun_cnt)
`endif
  );

  always #5 clk_pixel = ~clk_pixel;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] pix(input int l, input int c);
    return PW'((l << 8) | c);
  endfunction

  // Monitor: pulse counters and scoreboard compare of every displayed pixel.
  always @(negedge clk_pixel) begin
    if (line_req) lr_cnt++;
    if (frame_start) fs_cnt++;
    if (rd_de) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_pixel_unexpected: got %0h, expected no pixel", rd_pixel);
      end else begin
        check("rd_pixel", {40'h0, rd_pixel}, {40'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic push_pixel(input logic [PW-1:0] d);
    bit ok;
    ok = 1'b0;
    wr_valid = 1'b1;
    wr_data  = d;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk_pixel);
      if (wr_ready) ok = 1'b1;
      tick();
    end
    wr_valid = 1'b0;
    if (!ok) check("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic write_pixels(input int tag, input int first, input int n);
    for (int c = first; c < first + n; c++) push_pixel(pix(tag, c));
  endtask

  task automatic prefill(input int tag, output int acc);
    acc = 0;
    wr_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      wr_data = pix(tag + acc / H, acc % H);
      @(negedge clk_pixel);
      if (wr_ready) acc++;
      tick();
    end
    wr_valid = 1'b0;
  endtask

  task automatic scan_line(input int tag, input bit black);
    for (int c = 0; c < H; c++) begin
      de_in = 1'b1;
      x_pos = 3'(c);
      exp_q.push_back(black ? {PW{1'b0}} : pix(tag, c));
      tick();
    end
    de_in = 1'b0;
    x_pos = 3'd0;
  endtask

  task automatic vsync(input logic [RW-1:0] cfg);
    cfg_v_repeat = cfg;
    vsync_in = 1'b1;
    idle(3);
    vsync_in = 1'b0;
    idle(2);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_pixel"}, {40'h0, rd_pixel}, 64'd0);
    check({tag, "_rd_de"}, {63'h0, rd_de}, 64'd0);
    check({tag, "_line_req"}, {63'h0, line_req}, 64'd0);
    check({tag, "_frame_start"}, {63'h0, frame_start}, 64'd0);
    check({tag, "_fill_level"}, {61'h0, fill_level}, 64'd0);
    check({tag, "_underrun"}, {63'h0, underrun}, 64'd0);
    check({tag, "_wr_ready"}, {63'h0, wr_ready}, 64'd0);
  endtask

  initial begin
    int acc;
    int lr_exp;
    int fs_before;
    rst_n = 1'b0; cfg_v_repeat = 2'd0; wr_valid = 1'b0; wr_data = 24'h0;
    de_in = 1'b0; vsync_in = 1'b0; x_pos = 3'd0;
    lr_exp = 0;
    idle(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // 1: prefill until the ring is full
    prefill(0, acc);
    check("prefill_accepted", acc, 64'd32);
    check("prefill_wr_ready", {63'h0, wr_ready}, 64'd0);
    check("prefill_fill", {61'h0, fill_level}, 64'd4);

    // 2: scan one line
    scan_line(0, 1'b0);
    idle(4);
    lr_exp++;
    check("scan_fill", {61'h0, fill_level}, 64'd3);
    check("scan_line_req", lr_cnt, lr_exp);

    // 5a: commit coincides with the release at the end of line 1
    write_pixels(4, 0, 7);
    check("partial_fill", {61'h0, fill_level}, 64'd3);
    scan_line(1, 1'b0);
    wr_valid = 1'b1;
    wr_data  = pix(4, 7);
    @(negedge clk_pixel);
    check("commit_at_release_ready", {63'h0, wr_ready}, 64'd1);
    tick();
    wr_valid = 1'b0;
    idle(4);
    lr_exp++;
    check("commit_release_fill", {61'h0, fill_level}, 64'd3);
    check("commit_release_line_req", lr_cnt, lr_exp);
    scan_line(2, 1'b0);
    idle(4);
    lr_exp++;
    check("line2_fill", {61'h0, fill_level}, 64'd2);

    // 5b: vsync with a partial line at wr_col = 5, repeat factor 3
    write_pixels(5, 0, 5);
    fs_before = fs_cnt;
    vsync(2'd2);
    check("vsync_frame_start", fs_cnt, fs_before + 1);
    check("vsync_fill", {61'h0, fill_level}, 64'd0);

    // 3: repeat, first pixel after flush lands at {0,0}
    prefill(16, acc);
    check("refill_accepted", acc, 64'd32);
    scan_line(16, 1'b0);
    idle(4);
    check("rep1_line_req", lr_cnt, lr_exp);
    check("rep1_fill", {61'h0, fill_level}, 64'd4);
    scan_line(16, 1'b0);
    idle(4);
    check("rep2_line_req", lr_cnt, lr_exp);
    scan_line(16, 1'b0);
    idle(4);
    lr_exp++;
    check("rep3_line_req", lr_cnt, lr_exp);
    check("rep3_fill", {61'h0, fill_level}, 64'd3);
    scan_line(17, 1'b0);
    idle(4);
    check("rep_next_line_req", lr_cnt, lr_exp);

    // 4: underrun on an empty ring
    vsync(2'd0);
    check("pre_underrun_flag", {63'h0, underrun}, 64'd0);
    scan_line(0, 1'b1);
    idle(4);
    check("underrun_flag", {63'h0, underrun}, 64'd1);
    check("underrun_line_req", lr_cnt, lr_exp);
    check("underrun_fill", {61'h0, fill_level}, 64'd0);
`ifdef UNDERRUN_CNT_EN
    check("underrun_cnt", {48'h0, underrun_cnt}, 64'd1);
`endif
    write_pixels(32, 0, 8);
    check("after_underrun_fill", {61'h0, fill_level}, 64'd1);
    scan_line(32, 1'b0);
    idle(4);
    lr_exp++;
    check("after_underrun_line_req", lr_cnt, lr_exp);
    check("after_underrun_flag", {63'h0, underrun}, 64'd1);

    // 6: asynchronous reset in the middle of a displayed line
    write_pixels(40, 0, 8);
    for (int c = 0; c < 3; c++) begin
      de_in = 1'b1;
      x_pos = 3'(c);
      exp_q.push_back(pix(40, c));
      tick();
    end
    @(negedge clk_pixel);
    #2;
    rst_n = 1'b0;
    #1;
    check("midline_queue_drained", exp_q.size(), 64'd0);
    check_reset_outputs("async_reset");
    de_in = 1'b0;
    idle(2);
    rst_n = 1'b1;
    tick();
    prefill(48, acc);
    check("post_reset_accepted", acc, 64'd32);
    check("post_reset_fill", {61'h0, fill_level}, 64'd4);
    scan_line(48, 1'b0);
    idle(4);
    lr_exp++;
    check("post_reset_scan_fill", {61'h0, fill_level}, 64'd3);
    check("post_reset_line_req", lr_cnt, lr_exp);
    check("final_queue_empty", exp_q.size(), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
